// File: rtl/op_issue_ctrl_if.sv
// Instruction handshake and opcode-datapath bus between the issue controller
// (master) and the instruction source / datapath (slave).
interface op_issue_ctrl_if #(
   parameter int DATA_W = 20,
   parameter int RF_AW  = 4,
   parameter int OP_W   = 5
);
   logic              instr_valid;
   logic              instr_ready;
   logic [OP_W-1:0]   instr_op;
   logic [RF_AW-1:0]  instr_ra;
   logic [RF_AW-1:0]  instr_rb;
   logic [RF_AW-1:0]  instr_rd;
   logic [OP_W-1:0]   dp_op;
   logic [DATA_W-1:0] dp_a;
   logic [DATA_W-1:0] dp_b;
   logic [DATA_W-1:0] dp_w;
   logic              dp_carry;
   logic              dp_flag;

   modport master (
      input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      input  dp_w, dp_carry, dp_flag,
      output instr_ready, dp_op, dp_a, dp_b
   );

   modport slave (
      output instr_valid, instr_op, instr_ra, instr_rb, instr_rd,
      output dp_w, dp_carry, dp_flag,
      input  instr_ready, dp_op, dp_a, dp_b
   );
endinterface

// File: rtl/op_issue_ctrl.sv
// Issue controller for the 32-slot opcode datapath: owns a small register file,
// issues one instruction every 3 cycles and writes back result and flags.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for an instruction; host may write the register file
// EXEC   | operands on the datapath; result captured at end of cycle
// WB     | destination register, flags and retire count updated
// HALT   | TRAP executed; only host access works until reset
module op_issue_ctrl #(
   parameter int DATA_W = 20,
   parameter int RF_AW  = 4,
   parameter int OP_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   op_issue_ctrl_if.master     bus,
   input  logic                host_we,
   input  logic [RF_AW-1:0]    host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   output logic [DATA_W-1:0]   host_rdata,
   output logic                flag_c,
   output logic                flag_z,
   output logic                flag_s,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   localparam int RF_N = 2 ** RF_AW;

   localparam logic [OP_W-1:0] OP_TRAP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_NOP  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_NOT  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(10);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_INC  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_DEC  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(19);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(21);
   localparam logic [OP_W-1:0] OP_EQ   = OP_W'(22);
   localparam logic [OP_W-1:0] OP_GT   = OP_W'(23);
   localparam logic [OP_W-1:0] OP_LT   = OP_W'(24);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] rf_q [RF_N];
   logic [DATA_W-1:0] rf_d [RF_N];
   logic [OP_W-1:0]   dp_op_q, dp_op_d;
   logic [DATA_W-1:0] dp_a_q, dp_a_d;
   logic [DATA_W-1:0] dp_b_q, dp_b_d;
   logic [RF_AW-1:0]  rd_q, rd_d;
   logic [DATA_W-1:0] w_q, w_d;
   logic              carry_q, carry_d;
   logic              flag_q, flag_d;
   logic              flag_c_q, flag_c_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_s_q, flag_s_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              accept;
   logic              unary;

   assign accept = bus.instr_valid && (state_q == S_IDLE);
   assign unary  = (bus.instr_op == OP_NOT) || (bus.instr_op == OP_INC) ||
                   (bus.instr_op == OP_DEC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC:  state_d = (dp_op_q == OP_TRAP) ? S_HALT : S_WB;
         S_WB:    state_d = S_IDLE;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.instr_ready = (state_q == S_IDLE);
      bus.dp_op       = dp_op_q;
      bus.dp_a        = dp_a_q;
      bus.dp_b        = dp_b_q;
      host_rdata      = rf_q[host_addr];
      flag_c          = flag_c_q;
      flag_z          = flag_z_q;
      flag_s          = flag_s_q;
      halted          = halted_q;
      illegal         = illegal_q;
      retired         = retired_q;
   end

   always_comb begin
      rf_d      = rf_q;
      dp_op_d   = dp_op_q;
      dp_a_d    = dp_a_q;
      dp_b_d    = dp_b_q;
      rd_d      = rd_q;
      w_d       = w_q;
      carry_d   = carry_q;
      flag_d    = flag_q;
      flag_c_d  = flag_c_q;
      flag_z_d  = flag_z_q;
      flag_s_d  = flag_s_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      retired_d = retired_q;

      // operands sample rf_q, so a host write on the accept edge is not seen
      if (accept) begin
         dp_op_d = bus.instr_op;
         dp_a_d  = rf_q[bus.instr_ra];
         dp_b_d  = unary ? '0 : rf_q[bus.instr_rb];
         rd_d    = bus.instr_rd;
      end

      if (state_q == S_EXEC) begin
         w_d     = bus.dp_w;
         carry_d = bus.dp_carry;
         flag_d  = bus.dp_flag;
         if (dp_op_q == OP_TRAP) halted_d = 1'b1;
      end

      if (state_q == S_WB) begin
         retired_d = retired_q + CNT_W'(1);
         case (dp_op_q)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
               rf_d[rd_q] = w_q;
               flag_c_d   = carry_q;
               flag_z_d   = (w_q == '0);
            end
            OP_NOT, OP_AND, OP_OR, OP_XOR: begin
               rf_d[rd_q] = w_q;
               flag_z_d   = (w_q == '0);
            end
            OP_EQ:          flag_z_d = flag_q;
            OP_GT, OP_LT:   flag_s_d = flag_q;
            OP_NOP, OP_TRAP: ;
            default:        illegal_d = 1'b1;
         endcase
      end

      if (host_we && ((state_q == S_IDLE) || (state_q == S_HALT)))
         rf_d[host_addr] = host_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
         dp_op_q   <= '0;
         dp_a_q    <= '0;
         dp_b_q    <= '0;
         rd_q      <= '0;
         w_q       <= '0;
         carry_q   <= 1'b0;
         flag_q    <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_s_q  <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         rf_q      <= rf_d;
         dp_op_q   <= dp_op_d;
         dp_a_q    <= dp_a_d;
         dp_b_q    <= dp_b_d;
         rd_q      <= rd_d;
         w_q       <= w_d;
         carry_q   <= carry_d;
         flag_q    <= flag_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
         flag_s_q  <= flag_s_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_op_issue_ctrl.sv
// Directed bench for op_issue_ctrl with a behavioural 20-bit datapath on the
// slave side of the interface.
module tb_op_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        host_we;
   logic [3:0]  host_addr;
   logic [19:0] host_wdata;
   logic [19:0] host_rdata;
   logic        flag_c, flag_z, flag_s, halted, illegal;
   logic [15:0] retired;

   int          n_checks = 0;
   int          n_errors = 0;
   int          low_cycles;
   logic [4:0]  dp_op_exec;
   logic [19:0] dp_a_exec, dp_b_exec, rd_val;
   logic [20:0] dp_tmp;

   always #5 clk = ~clk;

   op_issue_ctrl_if #(.DATA_W(20), .RF_AW(4), .OP_W(5)) bus ();

   op_issue_ctrl #(.DATA_W(20), .RF_AW(4), .OP_W(5), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .flag_c     (flag_c),
      .flag_z     (flag_z),
      .flag_s     (flag_s),
      .halted     (halted),
      .illegal    (illegal),
      .retired    (retired)
   );

   // reference datapath: result, carry/borrow and compare flag from dp_op/a/b
   always_comb begin
      dp_tmp       = '0;
      bus.dp_flag  = 1'b0;
      case (bus.dp_op)
         5'd19:   dp_tmp = {1'b0, bus.dp_a} + {1'b0, bus.dp_b};
         5'd21:   dp_tmp = {1'b0, bus.dp_a} - {1'b0, bus.dp_b};
         5'd17:   dp_tmp = {1'b0, bus.dp_a} + 21'd1;
         5'd18:   dp_tmp = {1'b0, bus.dp_a} - 21'd1;
         5'd8:    dp_tmp = {1'b0, ~bus.dp_a};
         5'd9:    dp_tmp = {1'b0, bus.dp_a & bus.dp_b};
         5'd10:   dp_tmp = {1'b0, bus.dp_a | bus.dp_b};
         5'd11:   dp_tmp = {1'b0, bus.dp_a ^ bus.dp_b};
         5'd22:   bus.dp_flag = (bus.dp_a == bus.dp_b);
         5'd23:   bus.dp_flag = (bus.dp_a > bus.dp_b);
         5'd24:   bus.dp_flag = (bus.dp_a < bus.dp_b);
         default: dp_tmp = '0;
      endcase
      bus.dp_w     = dp_tmp[19:0];
      bus.dp_carry = dp_tmp[20];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [19:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a, output logic [19:0] d);
      host_addr = a;
      #1;
      d = host_rdata;
   endtask

   // poke 1: host write r1=0x77 on the accept edge; poke 2: host write r13 during EXEC
   task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rd, input int poke);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.instr_ready && guard < 20) begin
         guard++;
         @(negedge clk);
      end
      if (!bus.instr_ready) begin
         check_eq("accept_timeout", {31'd0, bus.instr_ready}, 32'd1);
         return;
      end
      bus.instr_valid = 1'b1;
      bus.instr_op = op; bus.instr_ra = ra; bus.instr_rb = rb; bus.instr_rd = rd;
      if (poke == 1) begin
         host_we = 1'b1; host_addr = 4'd1; host_wdata = 20'h00077;
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
      host_we = 1'b0;
      dp_op_exec = bus.dp_op;
      dp_a_exec  = bus.dp_a;
      dp_b_exec  = bus.dp_b;
      if (poke == 2) begin
         host_we = 1'b1; host_addr = 4'd13; host_wdata = 20'hABCDE;
      end
      low_cycles = 0;
      while (!bus.instr_ready && low_cycles < 10) begin
         low_cycles++;
         @(negedge clk);
         host_we = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0;
      bus.instr_valid = 1'b0; bus.instr_op = '0;
      bus.instr_ra = '0; bus.instr_rb = '0; bus.instr_rd = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
      check_eq("rst_retired", {16'd0, retired}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_flags", {29'd0, flag_c, flag_z, flag_s}, 32'd0);
      check_eq("rst_dp_op", {27'd0, bus.dp_op}, 32'd0);
      rst_n = 1'b1;

      // basic ADD, latency and readiness
      host_write(4'd1, 20'h00005);
      host_write(4'd2, 20'h00003);
      run_instr(5'd19, 4'd1, 4'd2, 4'd3, 0);
      check_eq("add_low_cycles", low_cycles, 32'd2);
      check_eq("add_dp_a", {12'd0, dp_a_exec}, 32'h5);
      check_eq("add_dp_b", {12'd0, dp_b_exec}, 32'h3);
      host_read(4'd3, rd_val);
      check_eq("add_r3", {12'd0, rd_val}, 32'h8);
      check_eq("add_cz", {30'd0, flag_c, flag_z}, 32'd0);
      check_eq("add_retired", {16'd0, retired}, 32'd1);

      // ADD overflow wraps to zero with carry
      host_write(4'd4, 20'hFFFFF);
      host_write(4'd5, 20'h00001);
      run_instr(5'd19, 4'd4, 4'd5, 4'd6, 0);
      host_read(4'd6, rd_val);
      check_eq("ovf_r6", {12'd0, rd_val}, 32'h0);
      check_eq("ovf_cz", {30'd0, flag_c, flag_z}, 32'd3);

      // compares: flags only, no register write
      run_instr(5'd22, 4'd1, 4'd2, 4'd9, 0);
      check_eq("eq_ne_z", {31'd0, flag_z}, 32'd0);
      run_instr(5'd22, 4'd1, 4'd1, 4'd9, 0);
      check_eq("eq_z", {31'd0, flag_z}, 32'd1);
      check_eq("eq_c_kept", {31'd0, flag_c}, 32'd1);
      run_instr(5'd24, 4'd2, 4'd1, 4'd9, 0);
      check_eq("lt_s", {31'd0, flag_s}, 32'd1);
      run_instr(5'd23, 4'd2, 4'd1, 4'd9, 0);
      check_eq("gt_s", {31'd0, flag_s}, 32'd0);
      host_read(4'd9, rd_val);
      check_eq("cmp_r9", {12'd0, rd_val}, 32'h0);
      host_read(4'd1, rd_val);
      check_eq("cmp_r1", {12'd0, rd_val}, 32'h5);
      host_read(4'd3, rd_val);
      check_eq("cmp_r3", {12'd0, rd_val}, 32'h8);
      check_eq("cmp_retired", {16'd0, retired}, 32'd6);

      // unary ops force operand B to zero
      run_instr(5'd8, 4'd0, 4'd2, 4'd7, 0);
      check_eq("not_dp_b", {12'd0, dp_b_exec}, 32'h0);
      host_read(4'd7, rd_val);
      check_eq("not_r7", {12'd0, rd_val}, 32'hFFFFF);
      check_eq("not_cz", {30'd0, flag_c, flag_z}, 32'd2);
      run_instr(5'd21, 4'd1, 4'd2, 4'd10, 0);
      host_read(4'd10, rd_val);
      check_eq("sub_r10", {12'd0, rd_val}, 32'h2);
      check_eq("sub_cz", {30'd0, flag_c, flag_z}, 32'd0);
      run_instr(5'd17, 4'd4, 4'd5, 4'd11, 0);
      check_eq("inc_dp_b", {12'd0, dp_b_exec}, 32'h0);
      host_read(4'd11, rd_val);
      check_eq("inc_r11", {12'd0, rd_val}, 32'h0);
      check_eq("inc_cz", {30'd0, flag_c, flag_z}, 32'd3);

      // illegal opcode retires as NOP
      host_write(4'd12, 20'h55555);
      run_instr(5'd12, 4'd1, 4'd2, 4'd12, 0);
      check_eq("ill_flag", {31'd0, illegal}, 32'd1);
      host_read(4'd12, rd_val);
      check_eq("ill_r12", {12'd0, rd_val}, 32'h55555);
      check_eq("ill_cz", {30'd0, flag_c, flag_z}, 32'd3);
      check_eq("ill_retired", {16'd0, retired}, 32'd10);

      // host write during EXEC is dropped
      run_instr(5'd1, 4'd1, 4'd2, 4'd13, 2);
      host_read(4'd13, rd_val);
      check_eq("exec_hw_r13", {12'd0, rd_val}, 32'h0);
      check_eq("nop_retired", {16'd0, retired}, 32'd11);

      // host write on the accept edge: operands see the old value
      run_instr(5'd19, 4'd1, 4'd1, 4'd14, 1);
      check_eq("same_edge_dp_a", {12'd0, dp_a_exec}, 32'h5);
      host_read(4'd14, rd_val);
      check_eq("same_edge_r14", {12'd0, rd_val}, 32'hA);
      host_read(4'd1, rd_val);
      check_eq("same_edge_r1", {12'd0, rd_val}, 32'h77);

      // TRAP halts, no retire, dp outputs hold
      run_instr(5'd0, 4'd2, 4'd2, 4'd0, 0);
      check_eq("trap_low", low_cycles, 32'd10);
      check_eq("trap_halted", {31'd0, halted}, 32'd1);
      check_eq("trap_retired", {16'd0, retired}, 32'd12);
      bus.instr_valid = 1'b1; bus.instr_op = 5'd19;
      repeat (3) @(negedge clk);
      check_eq("halt_ready", {31'd0, bus.instr_ready}, 32'd0);
      check_eq("halt_dp_a", {12'd0, bus.dp_a}, 32'h3);
      check_eq("halt_retired", {16'd0, retired}, 32'd12);
      bus.instr_valid = 1'b0;
      host_write(4'd8, 20'h12345);
      host_read(4'd8, rd_val);
      check_eq("halt_host_r8", {12'd0, rd_val}, 32'h12345);

      // reset leaves HALT and clears sticky state
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst2_status", {30'd0, halted, illegal}, 32'd0);
      check_eq("rst2_retired", {16'd0, retired}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset in the middle of EXEC drops the instruction
      host_write(4'd1, 20'hFFFFF);
      host_write(4'd2, 20'h00001);
      run_instr(5'd19, 4'd1, 4'd2, 4'd4, 0);
      check_eq("pre_cz", {30'd0, flag_c, flag_z}, 32'd3);
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.instr_op = 5'd19;
      bus.instr_ra = 4'd1; bus.instr_rb = 4'd1; bus.instr_rd = 4'd3;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check_eq("mid_exec_ready", {31'd0, bus.instr_ready}, 32'd0);
      check_eq("mid_exec_dp_a", {12'd0, bus.dp_a}, 32'hFFFFF);
      rst_n = 1'b0;
      #1;
      check_eq("abort_dp", {7'd0, bus.dp_op, bus.dp_a}, 32'd0);
      check_eq("abort_cz", {30'd0, flag_c, flag_z}, 32'd0);
      check_eq("abort_retired", {16'd0, retired}, 32'd0);
      host_read(4'd1, rd_val);
      check_eq("abort_r1", {12'd0, rd_val}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
      repeat (3) @(negedge clk);
      host_read(4'd3, rd_val);
      check_eq("abort_r3", {12'd0, rd_val}, 32'h0);
      check_eq("abort_retired2", {16'd0, retired}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
